// File: rtl/adpcm_pkg.sv
// Shared constants and types for the multi-channel IMA ADPCM engine:
// step table, index adjust table, op codes, Gray-coded FSM states.
package adpcm_pkg;

  typedef enum logic [1:0] {
    OP_ENC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // One bit changes per transition around the command loop.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_LOAD   = 3'b001,
    ST_B3     = 3'b011,
    ST_B2     = 3'b010,
    ST_B1     = 3'b110,
    ST_B0     = 3'b111,
    ST_UPDATE = 3'b101,
    ST_STEP   = 3'b100
  } state_e;

  localparam int IDX_MAX = 88;
  localparam logic signed [15:0] PCM_MAX = 16'sh7fff;
  localparam logic signed [15:0] PCM_MIN = 16'sh8000;

  localparam logic [15:0] STEP_TABLE [89] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  localparam logic signed [4:0] IDX_ADJ [8] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  // Per-command working registers; cleared as a unit on reset and disable.
  typedef struct packed {
    op_e                op;
    logic               ch_ok;
    logic signed [15:0] pcm_in;
    logic [3:0]         adpcm_in;
    logic [6:0]         idx_in;
    logic signed [15:0] pred;
    logic [6:0]         idx;
    logic [15:0]        step;
    logic [16:0]        sigma;
    logic [16:0]        diff;
    logic               sign;
    logic [2:0]         code;
    logic signed [15:0] new_pred;
    logic [6:0]         new_idx;
  } work_t;

  function automatic logic [6:0] idx_clamp(input logic signed [8:0] v);
    if (v < 0) return 7'd0;
    if (v > 9'sd88) return 7'd88;
    return v[6:0];
  endfunction

  function automatic logic signed [15:0] pcm_sat(input logic signed [17:0] v);
    if (v > PCM_MAX) return PCM_MAX;
    if (v < PCM_MIN) return PCM_MIN;
    return v[15:0];
  endfunction

endpackage

// File: rtl/adpcm_step_rom.sv
// Combinational step-index to quantiser step lookup.
module adpcm_step_rom
  import adpcm_pkg::*;
(
  input  logic [6:0]  idx_i,
  output logic [15:0] step_o
);

  always_comb begin
    step_o = STEP_TABLE[IDX_MAX];
    if (idx_i <= 7'(IDX_MAX)) step_o = STEP_TABLE[idx_i];
  end

endmodule

// File: rtl/adpcm_mc.sv
// Multi-channel IMA ADPCM codec: per-channel predictor/index contexts,
// one encode/decode/load/clear command per 8 cycles.
module adpcm_mc
  import adpcm_pkg::*;
#(
  parameter  int CH   = 4,
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                req,
  output logic                ack,
  input  logic [1:0]          op,
  input  logic [CH_W-1:0]     ch,
  input  logic signed [15:0]  rx_pcm,
  input  logic [3:0]          rx_adpcm,
  input  logic [6:0]          rx_idx,
  output logic signed [15:0]  tx_pcm,
  output logic [3:0]          tx_adpcm,
  output logic [CH_W-1:0]     tx_ch,
  output logic signed [15:0]  tx_predict,
  output logic [6:0]          tx_idx,
  output logic [2:0]          dbg_state
);

  // Handshake: each level change of req is one command. It is taken only
  // while ack is high (IDLE); a change seen while busy stays pending because
  // req_d_q is not updated until IDLE, so two changes while busy cancel out.
  state_e             state_q;
  logic               req_d_q;
  logic [CH_W-1:0]    ch_q;
  work_t              w_q;
  logic signed [15:0] ctx_pred_q [CH];
  logic [6:0]         ctx_idx_q  [CH];
  logic signed [15:0] tx_pcm_q;
  logic [3:0]         tx_adpcm_q;
  logic [CH_W-1:0]    tx_ch_q;
  logic signed [15:0] tx_predict_q;
  logic [6:0]         tx_idx_q;

  logic               req_x;
  logic signed [15:0] rd_pred;
  logic [6:0]         rd_idx;
  logic [15:0]        rom_step;
  logic [16:0]        diff_d;
  logic [1:0]         bit_d;
  logic               enc_hit;
  logic signed [17:0] p_d;
  logic signed [4:0]  adj_d;
  logic signed [8:0]  idx_sum_d;
  logic signed [15:0] new_pred_d;
  logic [6:0]         new_idx_d;

  assign req_x      = req ^ req_d_q;
  assign ack        = (state_q == ST_IDLE);
  assign dbg_state  = state_q;
  assign tx_pcm     = tx_pcm_q;
  assign tx_adpcm   = tx_adpcm_q;
  assign tx_ch      = tx_ch_q;
  assign tx_predict = tx_predict_q;
  assign tx_idx     = tx_idx_q;

  always_comb begin
    rd_pred = '0;
    rd_idx  = '0;
    if (w_q.ch_ok) begin
      rd_pred = ctx_pred_q[ch_q];
      rd_idx  = ctx_idx_q[ch_q];
    end
  end

  adpcm_step_rom u_step_rom (
    .idx_i  (rd_idx),
    .step_o (rom_step)
  );

  always_comb begin
    diff_d  = {w_q.pcm_in[15], w_q.pcm_in} - {rd_pred[15], rd_pred};
    enc_hit = (w_q.diff >= {1'b0, w_q.step});
    case (state_q)
      ST_B2:   bit_d = 2'd2;
      ST_B1:   bit_d = 2'd1;
      default: bit_d = 2'd0;
    endcase
    if (w_q.sign)
      p_d = $signed({{2{w_q.pred[15]}}, w_q.pred}) - $signed({1'b0, w_q.sigma});
    else
      p_d = $signed({{2{w_q.pred[15]}}, w_q.pred}) + $signed({1'b0, w_q.sigma});
    adj_d     = IDX_ADJ[w_q.code];
    idx_sum_d = $signed({2'b00, w_q.idx}) + $signed({{4{adj_d[4]}}, adj_d});
    case (w_q.op)
      OP_ENC, OP_DEC: begin
        new_pred_d = pcm_sat(p_d);
        new_idx_d  = idx_clamp(idx_sum_d);
      end
      OP_LOAD: begin
        new_pred_d = w_q.pcm_in;
        new_idx_d  = idx_clamp($signed({2'b00, w_q.idx_in}));
      end
      default: begin
        new_pred_d = '0;
        new_idx_d  = '0;
      end
    endcase
    if (!w_q.ch_ok) begin
      new_pred_d = '0;
      new_idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      req_d_q      <= 1'b0;
      ch_q         <= '0;
      w_q          <= '0;
      tx_pcm_q     <= '0;
      tx_adpcm_q   <= '0;
      tx_ch_q      <= '0;
      tx_predict_q <= '0;
      tx_idx_q     <= '0;
      for (int i = 0; i < CH; i++) begin
        ctx_pred_q[i] <= '0;
        ctx_idx_q[i]  <= '0;
      end
    end else if (!enable) begin
      state_q      <= ST_IDLE;
      req_d_q      <= 1'b0;
      ch_q         <= '0;
      w_q          <= '0;
      tx_pcm_q     <= '0;
      tx_adpcm_q   <= '0;
      tx_ch_q      <= '0;
      tx_predict_q <= '0;
      tx_idx_q     <= '0;
      for (int i = 0; i < CH; i++) begin
        ctx_pred_q[i] <= '0;
        ctx_idx_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_x) begin
            req_d_q      <= req;
            ch_q         <= ch;
            w_q.op       <= op_e'(op);
            w_q.ch_ok    <= (32'(ch) < CH);
            w_q.pcm_in   <= rx_pcm;
            w_q.adpcm_in <= rx_adpcm;
            w_q.idx_in   <= rx_idx;
            state_q      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_q.pred  <= rd_pred;
          w_q.idx   <= rd_idx;
          w_q.step  <= rom_step;
          w_q.sigma <= {4'b0000, rom_step[15:3]};
          w_q.diff  <= diff_d;
          w_q.sign  <= (w_q.op == OP_DEC) ? w_q.adpcm_in[3] : diff_d[16];
          w_q.code  <= (w_q.op == OP_DEC) ? w_q.adpcm_in[2:0] : 3'b000;
          state_q   <= ST_B3;
        end
        ST_B3: begin
          if (w_q.op == OP_ENC && w_q.sign) w_q.diff <= 17'd0 - w_q.diff;
          state_q <= ST_B2;
        end
        ST_B2, ST_B1, ST_B0: begin
          if (w_q.op == OP_ENC && enc_hit) begin
            w_q.code[bit_d] <= 1'b1;
            w_q.diff        <= w_q.diff - {1'b0, w_q.step};
            w_q.sigma       <= w_q.sigma + {1'b0, w_q.step};
          end else if (w_q.op == OP_DEC && w_q.code[bit_d]) begin
            w_q.sigma <= w_q.sigma + {1'b0, w_q.step};
          end
          if (state_q != ST_B0) w_q.step <= w_q.step >> 1;
          case (state_q)
            ST_B2:   state_q <= ST_B1;
            ST_B1:   state_q <= ST_B0;
            default: state_q <= ST_UPDATE;
          endcase
        end
        ST_UPDATE: begin
          w_q.new_pred <= new_pred_d;
          w_q.new_idx  <= new_idx_d;
          if (w_q.ch_ok) begin
            ctx_pred_q[ch_q] <= new_pred_d;
            ctx_idx_q[ch_q]  <= new_idx_d;
          end
          state_q <= ST_STEP;
        end
        ST_STEP: begin
          tx_ch_q      <= ch_q;
          tx_predict_q <= w_q.new_pred;
          tx_idx_q     <= w_q.new_idx;
          if (w_q.ch_ok && w_q.op == OP_ENC) tx_adpcm_q <= {w_q.sign, w_q.code};
          if (w_q.ch_ok && w_q.op == OP_DEC) tx_pcm_q <= w_q.new_pred;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_mc.sv
// Bench for adpcm_mc: directed scenarios plus randomized back-to-back
// commands checked against an arithmetic IMA ADPCM reference model.
module tb_adpcm_mc;

  logic               clk;
  logic               rstn;
  logic               enable;
  logic               req;
  logic               ack;
  logic [1:0]         op;
  logic [1:0]         ch;
  logic signed [15:0] rx_pcm;
  logic [3:0]         rx_adpcm;
  logic [6:0]         rx_idx;
  logic signed [15:0] tx_pcm;
  logic [3:0]         tx_adpcm;
  logic [1:0]         tx_ch;
  logic signed [15:0] tx_predict;
  logic [6:0]         tx_idx;
  logic [2:0]         dbg_state;

  int vectors;
  int miscompares;

  int m_pred [4];
  int m_idx  [4];
  logic signed [15:0] exp_pcm;
  logic [3:0]         exp_adpcm;
  logic [1:0]         exp_ch;
  logic signed [15:0] exp_pred;
  logic [6:0]         exp_idx;
  logic [44:0]        exp_q [$];

  int step_tab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  adpcm_mc #(.CH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .req        (req),
    .ack        (ack),
    .op         (op),
    .ch         (ch),
    .rx_pcm     (rx_pcm),
    .rx_adpcm   (rx_adpcm),
    .rx_idx     (rx_idx),
    .tx_pcm     (tx_pcm),
    .tx_adpcm   (tx_adpcm),
    .tx_ch      (tx_ch),
    .tx_predict (tx_predict),
    .tx_idx     (tx_idx),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Reference model: standard IMA ADPCM step on integers.
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pred[i] = 0;
      m_idx[i]  = 0;
    end
    exp_pcm = '0; exp_adpcm = '0; exp_ch = '0; exp_pred = '0; exp_idx = '0;
  endtask

  task automatic model_cmd(input int o, input int c, input int pcm, input int code, input int ix);
    int step, diff, vp, cd, sgn, p, ni;
    exp_ch = 2'(c);
    if (o == 0 || o == 1) begin
      step = step_tab[m_idx[c]];
      vp   = step / 8;
      cd   = 0;
      if (o == 0) begin
        diff = pcm - m_pred[c];
        sgn  = (diff < 0) ? 1 : 0;
        if (diff < 0) diff = -diff;
        for (int b = 2; b >= 0; b--) begin
          if (diff >= (step >> (2 - b))) begin
            cd   = cd + (1 << b);
            diff = diff - (step >> (2 - b));
            vp   = vp + (step >> (2 - b));
          end
        end
      end else begin
        sgn = (code >> 3) & 1;
        cd  = code & 7;
        for (int b = 2; b >= 0; b--)
          if (((cd >> b) & 1) == 1) vp = vp + (step >> (2 - b));
      end
      p = (sgn == 1) ? m_pred[c] - vp : m_pred[c] + vp;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      ni = m_idx[c] + ((cd < 4) ? -1 : 2 * (cd - 3));
      if (ni < 0) ni = 0;
      if (ni > 88) ni = 88;
      m_pred[c] = p;
      m_idx[c]  = ni;
      if (o == 0) exp_adpcm = 4'(sgn * 8 + cd);
      else        exp_pcm   = 16'(p);
    end else if (o == 2) begin
      m_pred[c] = pcm;
      m_idx[c]  = (ix > 88) ? 88 : ix;
    end else begin
      m_pred[c] = 0;
      m_idx[c]  = 0;
    end
    exp_pred = 16'(m_pred[c]);
    exp_idx  = 7'(m_idx[c]);
  endtask

  // Driver: called at a negedge while idle; returns edges until ack is back.
  task automatic run_cmd(input int o, input int c, input int pcm, input int code, input int ix,
                         output int lat);
    op = 2'(o); ch = 2'(c); rx_pcm = 16'(pcm); rx_adpcm = 4'(code); rx_idx = 7'(ix);
    req = ~req;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk); lat++;
    end while (!ack && lat < 20);
    model_cmd(o, c, pcm, code, ix);
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; req = 1'b0;
    op = '0; ch = '0; rx_pcm = '0; rx_adpcm = '0; rx_idx = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL reset_ack: got %b want 1", ack); end
    vectors++; if (tx_pcm !== 16'sd0) begin miscompares++; $display("FAIL reset_pcm: got %0d want 0", tx_pcm); end
    vectors++; if (tx_adpcm !== 4'h0) begin miscompares++; $display("FAIL reset_adpcm: got %h want 0", tx_adpcm); end
    vectors++; if (tx_ch !== 2'd0) begin miscompares++; $display("FAIL reset_ch: got %0d want 0", tx_ch); end
    vectors++; if (tx_predict !== 16'sd0) begin miscompares++; $display("FAIL reset_pred: got %0d want 0", tx_predict); end
    vectors++; if (tx_idx !== 7'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", tx_idx); end
    vectors++; if (dbg_state !== 3'b000) begin miscompares++; $display("FAIL reset_state: got %b want 000", dbg_state); end
  endtask

  task automatic test_encode_basic();
    int lat;
    run_cmd(0, 0, 1000, 0, 0, lat);
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL enc_latency: got %0d want 8", lat); end
    vectors++; if (tx_adpcm !== 4'h7) begin miscompares++; $display("FAIL enc_adpcm: got %h want 7", tx_adpcm); end
    vectors++; if (tx_predict !== 16'sd11) begin miscompares++; $display("FAIL enc_pred: got %0d want 11", tx_predict); end
    vectors++; if (tx_idx !== 7'd8) begin miscompares++; $display("FAIL enc_idx: got %0d want 8", tx_idx); end
    vectors++; if (tx_ch !== 2'd0) begin miscompares++; $display("FAIL enc_ch: got %0d want 0", tx_ch); end
  endtask

  task automatic test_decode_channels();
    int lat;
    run_cmd(1, 1, 0, 4'h7, 0, lat);
    vectors++; if (tx_pcm !== 16'sd11) begin miscompares++; $display("FAIL dec1_pcm: got %0d want 11", tx_pcm); end
    vectors++; if (tx_idx !== 7'd8) begin miscompares++; $display("FAIL dec1_idx: got %0d want 8", tx_idx); end
    vectors++; if (tx_ch !== 2'd1) begin miscompares++; $display("FAIL dec1_ch: got %0d want 1", tx_ch); end
    vectors++; if (tx_adpcm !== 4'h7) begin miscompares++; $display("FAIL dec1_adpcm_kept: got %h want 7", tx_adpcm); end
    run_cmd(1, 2, 0, 4'hF, 0, lat);
    vectors++; if (tx_pcm !== -16'sd11) begin miscompares++; $display("FAIL dec2_pcm: got %0d want -11", tx_pcm); end
    vectors++; if (tx_idx !== 7'd8) begin miscompares++; $display("FAIL dec2_idx: got %0d want 8", tx_idx); end
    run_cmd(1, 0, 0, 4'h0, 0, lat);
    vectors++; if (tx_idx !== 7'd7) begin miscompares++; $display("FAIL ch0_idx: got %0d want 7", tx_idx); end
    vectors++; if (tx_pcm !== exp_pcm) begin miscompares++; $display("FAIL ch0_pcm: got %0d want %0d", tx_pcm, exp_pcm); end
  endtask

  task automatic test_load_clear();
    int lat;
    run_cmd(2, 3, 32760, 0, 100, lat);
    vectors++; if (tx_idx !== 7'd88) begin miscompares++; $display("FAIL load_idx: got %0d want 88", tx_idx); end
    vectors++; if (tx_predict !== 16'sd32760) begin miscompares++; $display("FAIL load_pred: got %0d want 32760", tx_predict); end
    vectors++; if (tx_pcm !== exp_pcm) begin miscompares++; $display("FAIL load_pcm_kept: got %0d want %0d", tx_pcm, exp_pcm); end
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL load_latency: got %0d want 8", lat); end
    run_cmd(1, 3, 0, 4'h7, 0, lat);
    vectors++; if (tx_pcm !== 16'sd32767) begin miscompares++; $display("FAIL sat_pcm: got %0d want 32767", tx_pcm); end
    vectors++; if (tx_idx !== 7'd88) begin miscompares++; $display("FAIL sat_idx: got %0d want 88", tx_idx); end
    run_cmd(3, 3, 0, 0, 0, lat);
    vectors++; if (tx_predict !== 16'sd0) begin miscompares++; $display("FAIL clr_pred: got %0d want 0", tx_predict); end
    vectors++; if (tx_adpcm !== exp_adpcm) begin miscompares++; $display("FAIL clr_adpcm_kept: got %h want %h", tx_adpcm, exp_adpcm); end
    run_cmd(1, 3, 0, 4'h0, 0, lat);
    vectors++; if (tx_pcm !== 16'sd0) begin miscompares++; $display("FAIL lowclamp_pcm: got %0d want 0", tx_pcm); end
    vectors++; if (tx_idx !== 7'd0) begin miscompares++; $display("FAIL lowclamp_idx: got %0d want 0", tx_idx); end
  endtask

  task automatic test_double_toggle();
    int n, extra;
    op = 2'd0; ch = 2'd1; rx_pcm = -16'sd500; rx_adpcm = '0; rx_idx = '0;
    req = ~req;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 2 || n == 3) req = ~req;
    end while (!ack && n < 20);
    model_cmd(0, 1, -500, 0, 0);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL dbl_latency: got %0d want 8", n); end
    extra = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (!ack) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL dbl_extra_cmd: busy cycles %0d want 0", extra); end
    vectors++; if (tx_predict !== exp_pred) begin miscompares++; $display("FAIL dbl_pred: got %0d want %0d", tx_predict, exp_pred); end
    vectors++; if (tx_adpcm !== exp_adpcm) begin miscompares++; $display("FAIL dbl_adpcm: got %h want %h", tx_adpcm, exp_adpcm); end
  endtask

  task automatic test_single_toggle();
    int n, m;
    op = 2'd0; ch = 2'd2; rx_pcm = 16'sd3000; rx_adpcm = '0; rx_idx = '0;
    req = ~req;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 3) begin
        op = 2'd1; ch = 2'd2; rx_adpcm = 4'hA; rx_pcm = '0;
        req = ~req;
      end
    end while (!ack && n < 20);
    model_cmd(0, 2, 3000, 0, 0);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL pend_first_latency: got %0d want 8", n); end
    vectors++; if (tx_adpcm !== exp_adpcm) begin miscompares++; $display("FAIL pend_first_adpcm: got %h want %h", tx_adpcm, exp_adpcm); end
    @(posedge clk); @(negedge clk);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL pend_taken: ack %b want 0", ack); end
    m = 1;
    while (!ack && m < 20) begin
      @(posedge clk); @(negedge clk); m++;
    end
    model_cmd(1, 2, 0, 4'hA, 0);
    vectors++; if (m !== 8) begin miscompares++; $display("FAIL pend_second_latency: got %0d want 8", m); end
    vectors++; if (tx_pcm !== exp_pcm) begin miscompares++; $display("FAIL pend_second_pcm: got %0d want %0d", tx_pcm, exp_pcm); end
    vectors++; if (tx_idx !== exp_idx) begin miscompares++; $display("FAIL pend_second_idx: got %0d want %0d", tx_idx, exp_idx); end
  endtask

  task automatic test_enable_abort();
    int n, busy, lat;
    op = 2'd0; ch = 2'd0; rx_pcm = 16'sd2000; rx_adpcm = '0; rx_idx = '0;
    req = ~req;
    n = 0;
    while (n < 3) begin
      @(posedge clk); @(negedge clk); n++;
    end
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    model_reset();
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL abort_ack: got %b want 1", ack); end
    vectors++; if ({tx_pcm, tx_adpcm, tx_ch, tx_predict, tx_idx} !== 45'd0)
      begin miscompares++; $display("FAIL abort_outputs: got pcm %0d adpcm %h ch %0d pred %0d idx %0d want all 0", tx_pcm, tx_adpcm, tx_ch, tx_predict, tx_idx); end
    @(negedge clk);
    enable = 1'b1;
    busy = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (!ack) busy++;
    end
    vectors++; if (busy !== 0) begin miscompares++; $display("FAIL abort_spurious: busy cycles %0d want 0", busy); end
    run_cmd(0, 0, 1000, 0, 0, lat);
    vectors++; if (tx_adpcm !== 4'h7) begin miscompares++; $display("FAIL abort_enc_adpcm: got %h want 7", tx_adpcm); end
    vectors++; if (tx_predict !== 16'sd11) begin miscompares++; $display("FAIL abort_enc_pred: got %0d want 11", tx_predict); end
    vectors++; if (tx_idx !== 7'd8) begin miscompares++; $display("FAIL abort_enc_idx: got %0d want 8", tx_idx); end
  endtask

  task automatic test_back_to_back();
    int o, c, pcm, code, ix, r, lat;
    logic [44:0] got, e;
    for (int k = 0; k < 40; k++) begin
      r    = int'($urandom_range(0, 9));
      o    = (r < 4) ? 0 : (r < 8) ? 1 : r - 6;
      c    = int'($urandom_range(0, 3));
      pcm  = int'($urandom_range(0, 65535)) - 32768;
      code = int'($urandom_range(0, 15));
      ix   = int'($urandom_range(0, 127));
      run_cmd(o, c, pcm, code, ix, lat);
      exp_q.push_back({exp_pcm, exp_adpcm, exp_ch, exp_pred, exp_idx});
      vectors++; if (lat !== 8) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d want 8", k, lat); end
      got = {tx_pcm, tx_adpcm, tx_ch, tx_predict, tx_idx};
      e   = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL b2b_result[%0d] op %0d ch %0d: got pcm %0d adpcm %h ch %0d pred %0d idx %0d, want pcm %0d adpcm %h ch %0d pred %0d idx %0d",
                 k, o, c, $signed(got[44:29]), got[28:25], got[24:23], $signed(got[22:7]), got[6:0],
                 $signed(e[44:29]), e[28:25], e[24:23], $signed(e[22:7]), e[6:0]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_encode_basic();
    test_decode_channels();
    test_load_clear();
    test_double_toggle();
    test_single_toggle();
    test_enable_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
